// File: rtl/mesm6_defines.sv
// Shared MESM-6 bus constants and the bus arbiter's state type.
package mesm6_defines;

    localparam int ADDR_W      = 15;
    localparam int DATA_W      = 48;
    localparam int BUS_TIMEOUT = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    // Watchdog counter width; a disabled watchdog still keeps a 1-bit register.
    function automatic int wdog_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mesm6_bus_watchdog.sv
// Grant-age counter: cleared while the bus is idle, counts granted cycles and
// flags the cycle in which a hung transaction must be terminated.
module mesm6_bus_watchdog
    import mesm6_defines::*;
#(
    parameter int TIMEOUT = BUS_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int W = wdog_width(TIMEOUT);
    localparam logic [W-1:0] LIMIT = (TIMEOUT == 0) ? '0 : W'(TIMEOUT - 1);
    localparam logic ENABLED = (TIMEOUT != 0);

    logic [W-1:0] wdog_q, wdog_d;

    always_comb begin
        wdog_d = wdog_q;
        if (clear_i)
            wdog_d = '0;
        else if (enable_i && (wdog_q != LIMIT))
            wdog_d = wdog_q + W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wdog_q <= '0;
        else
            wdog_q <= wdog_d;
    end

    assign expire_o = ENABLED && (wdog_q == LIMIT);

endmodule

// File: rtl/mesm6_bus_arbiter.sv
// Two-master round-robin arbiter for the MESM-6 memory/device bus with a
// watchdog that terminates hung transactions with a one-cycle bus_error.
module mesm6_bus_arbiter
    import mesm6_defines::*;
#(
    parameter int TIMEOUT = BUS_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_done,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_done,
    output logic [ADDR_W-1:0] slv_addr,
    output logic              slv_read,
    output logic              slv_write,
    output logic [DATA_W-1:0] slv_wdata,
    input  logic [DATA_W-1:0] slv_rdata,
    input  logic              slv_done,
    output logic              bus_error
);

    arb_state_t state_q, state_d;
    logic       last_q, last_d;
    logic       req0, req1;
    logic       expire;
    logic       finish;
    logic       abort;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    mesm6_bus_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (state_q == IDLE),
        .enable_i (state_q != IDLE),
        .expire_o (expire)
    );

    // A real slv_done always takes priority over the watchdog.
    assign abort  = expire && !slv_done;
    assign finish = slv_done || abort;

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        slv_addr  = '0;
        slv_read  = 1'b0;
        slv_write = 1'b0;
        slv_wdata = '0;
        m0_done   = 1'b0;
        m1_done   = 1'b0;
        m0_rdata  = '0;
        m1_rdata  = '0;
        bus_error = 1'b0;
        case (state_q)
            IDLE: begin
                // last_q == 1 means m1 was served last, so m0 wins a tie.
                if (req0 && (!req1 || last_q)) begin
                    state_d = GNT0;
                    last_d  = 1'b0;
                end else if (req1) begin
                    state_d = GNT1;
                    last_d  = 1'b1;
                end
            end
            GNT0: begin
                slv_addr  = m0_addr;
                slv_wdata = m0_wdata;
                slv_read  = m0_read && !abort;
                slv_write = m0_write && !abort;
                m0_done   = finish;
                m0_rdata  = abort ? '0 : slv_rdata;
                bus_error = abort;
                if (finish)
                    state_d = IDLE;
            end
            GNT1: begin
                slv_addr  = m1_addr;
                slv_wdata = m1_wdata;
                slv_read  = m1_read && !abort;
                slv_write = m1_write && !abort;
                m1_done   = finish;
                m1_rdata  = abort ? '0 : slv_rdata;
                bus_error = abort;
                if (finish)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

endmodule
